// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared types for the pipeline controller: per-latch command
//                encoding and controller state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_types_pkg;

    // Command applied to each inter-stage pipeline latch
    typedef enum logic [1:0] {
        PIPE_ENABLE = 2'b00,   // load next values
        PIPE_STALL  = 2'b01,   // hold current values
        PIPE_NOP    = 2'b10    // load a bubble (all fields zero)
    } pipe_state_t;

    // Controller state
    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } ctrl_state_t;

    // Register-select width used by the hazard comparators
    localparam int unsigned REG_SEL_W = 5;

endpackage
`default_nettype wire

// File: rtl/pipeline_controller_perf_counters.sv
`default_nettype none
// ============================================================================
//  Module      : perf_counters
//  Description : Stall-cycle counter (saturating, 32 bit) and flush counter
//                (wrapping, 16 bit) for the pipeline controller.
//  Revision    : 1.0  initial release
// ============================================================================
module perf_counters #(
    // Value loaded into the flush counter on reset; zero in normal use
    parameter logic [15:0] FLUSH_CNT_INIT = 16'h0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        stall_inc,
    input  logic        flush_inc,
    output logic [31:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    logic [31:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    // Count stall cycles (saturating) and flushes (wrapping)
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= 32'h0000_0000;
            r_flush_cnt <= FLUSH_CNT_INIT;
        end else begin
            if (stall_inc && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (flush_inc) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: rtl/pipeline_controller.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_controller
//  Description : Hazard decode and per-latch command generation for a
//                five-stage pipeline, with halt drain and perf counters.
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_controller
    import cpu_types_pkg::*;
#(
    // Reset value of the flush counter; zero in normal use
    parameter logic [15:0] FLUSH_CNT_INIT = 16'h0000
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ihit,
    input  logic                 dhit,
    input  logic                 dmemREN_mem,
    input  logic                 dmemWEN_mem,
    input  logic                 MemRead_ex,
    input  logic [REG_SEL_W-1:0] regWSEL_ex,
    input  logic [REG_SEL_W-1:0] rs_id,
    input  logic [REG_SEL_W-1:0] rt_id,
    input  logic                 branch_taken_mem,
    input  logic                 halt_mem,
    output logic                 pc_en,
    output pipe_state_t          fd_state,
    output pipe_state_t          de_state,
    output pipe_state_t          em_state,
    output pipe_state_t          mw_state,
    output logic                 halted,
    output logic [31:0]          stall_cnt,
    output logic [15:0]          flush_cnt
);

    ctrl_state_t r_state;
    ctrl_state_t w_next_state;
    logic        r_halted;

    logic w_mem_stall;
    logic w_load_use;
    logic w_halt_entry;
    logic w_stall_inc;
    logic w_flush_inc;

    // Hazard decode
    assign w_mem_stall  = (dmemREN_mem | dmemWEN_mem) & ~dhit;
    assign w_load_use   = MemRead_ex & (regWSEL_ex != '0) &
                          ((regWSEL_ex == rs_id) | (regWSEL_ex == rt_id));
    // A halt only commits once any outstanding data access has completed
    assign w_halt_entry = halt_mem & ~w_mem_stall;

    // State register; halted tracks the state being entered
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= RUN;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_halted <= (w_next_state == HALTED);
        end
    end

    // Next-state logic: RUN -> DRAIN on halt, DRAIN -> HALTED, HALTED is sticky
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN:     if (w_halt_entry) w_next_state = DRAIN;
            DRAIN:   w_next_state = HALTED;
            HALTED:  w_next_state = HALTED;
            default: w_next_state = RUN;
        endcase
    end

    // Output logic: prioritised latch commands and counter strobes
    always_comb begin
        pc_en       = 1'b0;
        fd_state    = PIPE_NOP;
        de_state    = PIPE_NOP;
        em_state    = PIPE_NOP;
        mw_state    = PIPE_NOP;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;
        if (!RST) begin
            case (r_state)
                RUN: begin
                    if (w_halt_entry) begin
                        mw_state = PIPE_ENABLE;
                    end else if (w_mem_stall) begin
                        fd_state    = PIPE_STALL;
                        de_state    = PIPE_STALL;
                        em_state    = PIPE_STALL;
                        mw_state    = PIPE_NOP;
                        w_stall_inc = 1'b1;
                    end else if (branch_taken_mem) begin
                        pc_en       = 1'b1;
                        mw_state    = PIPE_ENABLE;
                        w_flush_inc = 1'b1;
                    end else if (w_load_use) begin
                        fd_state    = PIPE_STALL;
                        de_state    = PIPE_NOP;
                        em_state    = PIPE_ENABLE;
                        mw_state    = PIPE_ENABLE;
                        w_stall_inc = 1'b1;
                    end else if (!ihit) begin
                        fd_state    = PIPE_NOP;
                        de_state    = PIPE_ENABLE;
                        em_state    = PIPE_ENABLE;
                        mw_state    = PIPE_ENABLE;
                        w_stall_inc = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        fd_state = PIPE_ENABLE;
                        de_state = PIPE_ENABLE;
                        em_state = PIPE_ENABLE;
                        mw_state = PIPE_ENABLE;
                    end
                end
                DRAIN, HALTED: begin
                    mw_state = PIPE_STALL;
                end
                default: begin
                    mw_state = PIPE_NOP;
                end
            endcase
        end
    end

    assign halted = r_halted;

    perf_counters #(
        .FLUSH_CNT_INIT (FLUSH_CNT_INIT)
    ) u_perf_counters (
        .CLK       (CLK),
        .RST       (RST),
        .stall_inc (w_stall_inc),
        .flush_inc (w_flush_inc),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_controller
//  Description : Scoreboard bench for pipeline_controller. A second instance
//                starts its flush counter at 0xFFFF to exercise the wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_controller;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST, ihit, dhit, dmemREN_mem, dmemWEN_mem, MemRead_ex;
    logic        branch_taken_mem, halt_mem;
    logic [4:0]  regWSEL_ex, rs_id, rt_id;

    logic        pc_en, halted, pc_en2, halted2;
    pipe_state_t fd_state, de_state, em_state, mw_state;
    pipe_state_t fd_state2, de_state2, em_state2, mw_state2;
    logic [31:0] stall_cnt, stall_cnt2;
    logic [15:0] flush_cnt, flush_cnt2;

    pipeline_controller dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .dmemREN_mem(dmemREN_mem), .dmemWEN_mem(dmemWEN_mem),
        .MemRead_ex(MemRead_ex), .regWSEL_ex(regWSEL_ex),
        .rs_id(rs_id), .rt_id(rt_id),
        .branch_taken_mem(branch_taken_mem), .halt_mem(halt_mem),
        .pc_en(pc_en), .fd_state(fd_state), .de_state(de_state),
        .em_state(em_state), .mw_state(mw_state), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_controller #(.FLUSH_CNT_INIT(16'hFFFF)) dut_wrap (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .dmemREN_mem(dmemREN_mem), .dmemWEN_mem(dmemWEN_mem),
        .MemRead_ex(MemRead_ex), .regWSEL_ex(regWSEL_ex),
        .rs_id(rs_id), .rt_id(rt_id),
        .branch_taken_mem(branch_taken_mem), .halt_mem(halt_mem),
        .pc_en(pc_en2), .fd_state(fd_state2), .de_state(de_state2),
        .em_state(em_state2), .mw_state(mw_state2), .halted(halted2),
        .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    logic [8:0]  sb_q[$];
    logic [8:0]  g_val, e_val;
    int unsigned m_stall;
    logic [15:0] m_flush, m_flush2;

    function automatic logic [8:0] mk(input logic pc, input pipe_state_t fd,
                                      input pipe_state_t de, input pipe_state_t em,
                                      input pipe_state_t mw);
        return {pc, fd, de, em, mw};
    endfunction

    function automatic logic [8:0] observed();
        return {pc_en, fd_state, de_state, em_state, mw_state};
    endfunction

    task automatic set_idle();
        RST = 1'b0; ihit = 1'b1; dhit = 1'b1;
        dmemREN_mem = 1'b0; dmemWEN_mem = 1'b0; MemRead_ex = 1'b0;
        regWSEL_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0;
        branch_taken_mem = 1'b0; halt_mem = 1'b0;
    endtask

    // Queue the expected latch commands for this cycle and advance the counter model
    task automatic sb_push(input logic [8:0] e, input bit sinc, input bit finc);
        sb_q.push_back(e);
        if (sinc) m_stall = m_stall + 1;
        if (finc) begin
            m_flush  = m_flush + 16'd1;
            m_flush2 = m_flush2 + 16'd1;
        end
    endtask

    task automatic test_reset();
        set_idle(); RST = 1'b1;
        m_stall = 0; m_flush = 16'h0000; m_flush2 = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            sb_push(mk(1'b0, PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_NOP), 1'b0, 1'b0);
            #1; g_val = observed(); e_val = sb_q.pop_front(); n_total++;
            if (g_val !== e_val) $display("FAIL reset_out[%0d]: got %b exp %b", i, g_val, e_val);
            else n_pass++;
        end
        n_total++;
        if (halted !== 1'b0) $display("FAIL reset_halted: got %b exp 0", halted); else n_pass++;
        n_total++;
        if (stall_cnt !== m_stall) $display("FAIL reset_stall: got %0d exp %0d", stall_cnt, m_stall); else n_pass++;
        n_total++;
        if (flush_cnt !== m_flush) $display("FAIL reset_flush: got %h exp %h", flush_cnt, m_flush); else n_pass++;
        n_total++;
        if (flush_cnt2 !== m_flush2) $display("FAIL reset_flush_preload: got %h exp %h", flush_cnt2, m_flush2); else n_pass++;
        @(negedge CLK); set_idle();
        sb_push(mk(1'b1, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE), 1'b0, 1'b0);
        #1; g_val = observed(); e_val = sb_q.pop_front(); n_total++;
        if (g_val !== e_val) $display("FAIL run_idle: got %b exp %b", g_val, e_val); else n_pass++;
        @(negedge CLK); set_idle(); #1;
        n_total++;
        if (stall_cnt !== m_stall || flush_cnt !== m_flush)
            $display("FAIL idle_counters: got %0d/%0d exp %0d/%0d", stall_cnt, flush_cnt, m_stall, m_flush);
        else n_pass++;
    endtask

    task automatic test_mem_stall();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK); set_idle();
            if (i < 3) begin
                dmemREN_mem = 1'b1; dhit = 1'b0;
                sb_push(mk(1'b0, PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_NOP), 1'b1, 1'b0);
            end else if (i == 3) begin
                dmemREN_mem = 1'b1; dhit = 1'b1;
                sb_push(mk(1'b1, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE), 1'b0, 1'b0);
            end else begin
                dmemWEN_mem = 1'b1; dhit = 1'b0;
                sb_push(mk(1'b0, PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_NOP), 1'b1, 1'b0);
            end
            #1; g_val = observed(); e_val = sb_q.pop_front(); n_total++;
            if (g_val !== e_val) $display("FAIL mem_stall[%0d]: got %b exp %b", i, g_val, e_val);
            else n_pass++;
        end
        @(negedge CLK); set_idle(); #1; n_total++;
        if (stall_cnt !== m_stall) $display("FAIL mem_stall_cnt: got %0d exp %0d", stall_cnt, m_stall);
        else n_pass++;
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK); set_idle();
            case (i)
                0: begin MemRead_ex = 1'b1; regWSEL_ex = 5'd5; rs_id = 5'd3; rt_id = 5'd5; end
                1: begin MemRead_ex = 1'b1; regWSEL_ex = 5'd5; rs_id = 5'd5; rt_id = 5'd9; end
                2: begin MemRead_ex = 1'b1; regWSEL_ex = 5'd5; rs_id = 5'd3; rt_id = 5'd5; ihit = 1'b0; end
                3: begin MemRead_ex = 1'b1; regWSEL_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0; end
                4: begin MemRead_ex = 1'b1; regWSEL_ex = 5'd5; rs_id = 5'd6; rt_id = 5'd7; end
                5: begin MemRead_ex = 1'b0; regWSEL_ex = 5'd5; rs_id = 5'd5; rt_id = 5'd5; end
                default: ihit = 1'b0;
            endcase
            if (i < 3)
                sb_push(mk(1'b0, PIPE_STALL, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE), 1'b1, 1'b0);
            else if (i < 6)
                sb_push(mk(1'b1, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE), 1'b0, 1'b0);
            else
                sb_push(mk(1'b0, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE), 1'b1, 1'b0);
            #1; g_val = observed(); e_val = sb_q.pop_front(); n_total++;
            if (g_val !== e_val) $display("FAIL load_use[%0d]: got %b exp %b", i, g_val, e_val);
            else n_pass++;
        end
        @(negedge CLK); set_idle(); #1; n_total++;
        if (stall_cnt !== m_stall) $display("FAIL load_use_cnt: got %0d exp %0d", stall_cnt, m_stall);
        else n_pass++;
    endtask

    task automatic test_branch_under_stall();
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK); set_idle();
            if (i < 3) begin branch_taken_mem = 1'b1; dmemREN_mem = 1'b1; end
            if (i < 2) begin
                dhit = 1'b0;
                sb_push(mk(1'b0, PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_NOP), 1'b1, 1'b0);
            end else if (i == 2) begin
                sb_push(mk(1'b1, PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_ENABLE), 1'b0, 1'b1);
            end else begin
                sb_push(mk(1'b1, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE), 1'b0, 1'b0);
            end
            #1; g_val = observed(); e_val = sb_q.pop_front(); n_total++;
            if (g_val !== e_val) $display("FAIL branch[%0d]: got %b exp %b", i, g_val, e_val);
            else n_pass++;
        end
        @(negedge CLK); set_idle(); #1;
        n_total++;
        if (stall_cnt !== m_stall) $display("FAIL branch_stall_cnt: got %0d exp %0d", stall_cnt, m_stall); else n_pass++;
        n_total++;
        if (flush_cnt !== m_flush) $display("FAIL branch_flush_cnt: got %h exp %h", flush_cnt, m_flush); else n_pass++;
        n_total++;
        if (flush_cnt2 !== m_flush2) $display("FAIL flush_wrap: got %h exp %h", flush_cnt2, m_flush2); else n_pass++;
    endtask

    task automatic test_halt();
        for (int i = 0; i < 13; i++) begin
            @(negedge CLK); set_idle();
            if (i == 0) begin
                halt_mem = 1'b1; dmemREN_mem = 1'b1; dhit = 1'b0;
                sb_push(mk(1'b0, PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_NOP), 1'b1, 1'b0);
            end else if (i == 1) begin
                halt_mem = 1'b1; dmemREN_mem = 1'b1;
                sb_push(mk(1'b0, PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_ENABLE), 1'b0, 1'b0);
            end else begin
                if (i > 2) begin
                    ihit = 1'($urandom); dhit = 1'($urandom);
                    dmemREN_mem = 1'($urandom); dmemWEN_mem = 1'($urandom);
                    MemRead_ex = 1'($urandom); regWSEL_ex = 5'($urandom);
                    rs_id = 5'($urandom); rt_id = 5'($urandom);
                    branch_taken_mem = 1'($urandom); halt_mem = 1'($urandom);
                end
                sb_push(mk(1'b0, PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_STALL), 1'b0, 1'b0);
            end
            #1; g_val = observed(); e_val = sb_q.pop_front(); n_total++;
            if (g_val !== e_val) $display("FAIL halt[%0d]: got %b exp %b", i, g_val, e_val);
            else n_pass++;
            n_total++;
            if (halted !== (i > 2)) $display("FAIL halt_flag[%0d]: got %b exp %b", i, halted, (i > 2));
            else n_pass++;
        end
        @(negedge CLK); set_idle(); #1; n_total++;
        if (stall_cnt !== m_stall || flush_cnt !== m_flush)
            $display("FAIL halt_counters: got %0d/%0d exp %0d/%0d", stall_cnt, flush_cnt, m_stall, m_flush);
        else n_pass++;
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK); set_idle();
            if (i == 0 || i == 3) begin
                RST = 1'b1;
                m_stall = 0; m_flush = 16'h0000; m_flush2 = 16'hFFFF;
                sb_push(mk(1'b0, PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_NOP), 1'b0, 1'b0);
            end else if (i == 2) begin
                halt_mem = 1'b1;
                sb_push(mk(1'b0, PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_ENABLE), 1'b0, 1'b0);
            end else begin
                sb_push(mk(1'b1, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE), 1'b0, 1'b0);
            end
            #1; g_val = observed(); e_val = sb_q.pop_front(); n_total++;
            if (g_val !== e_val) $display("FAIL rst_drain[%0d]: got %b exp %b", i, g_val, e_val);
            else n_pass++;
            if (i >= 4) begin
                n_total++;
                if (halted !== 1'b0) $display("FAIL rst_drain_halted[%0d]: got %b exp 0", i, halted);
                else n_pass++;
            end
        end
        @(negedge CLK); set_idle(); #1; n_total++;
        if (stall_cnt !== m_stall || flush_cnt !== m_flush)
            $display("FAIL rst_drain_counters: got %0d/%0d exp %0d/%0d", stall_cnt, flush_cnt, m_stall, m_flush);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_mem_stall();
        test_load_use();
        test_branch_under_stall();
        test_halt();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
